// File: rtl/ascon_job_sched_pkg.sv
// Shared types and constants for the ASCON job scheduler.
package ascon_pack;

    localparam int WDOG_DEF_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        ABORT = 2'd3
    } sched_state_e;

    // Plain-vector aliases of the scheduler states for the state register.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_ABORT = ABORT;

endpackage

// File: rtl/ascon_job_sched_if.sv
// Requester-side bundle: job descriptors, data streams and result strobes.
interface ascon_job_sched_if #(
    parameter int NREQ      = 2,
    parameter int BLK_AD_AW = 10,
    parameter int BLK_PT_AW = 10
);
    logic [NREQ-1:0]           job_valid_i;
    logic [NREQ-1:0]           job_ready_o;
    logic [NREQ*128-1:0]       job_key_i;
    logic [NREQ*128-1:0]       job_nonce_i;
    logic [NREQ*BLK_AD_AW-1:0] job_ad_size_i;
    logic [NREQ*BLK_PT_AW-1:0] job_pt_size_i;
    logic [NREQ*8-1:0]         job_delay_i;
    logic [NREQ-1:0]           data_valid_i;
    logic [NREQ*64-1:0]        data_i;
    logic [NREQ-1:0]           data_ready_o;
    logic [NREQ-1:0]           ct_valid_o;
    logic [63:0]               ct_o;
    logic [NREQ-1:0]           tag_valid_o;
    logic [127:0]              tag_o;
    logic [NREQ-1:0]           done_o;
    logic [NREQ-1:0]           error_o;
    logic                      busy_o;

    // Requester side: issues jobs and data, receives results.
    modport master (
        output job_valid_i, job_key_i, job_nonce_i, job_ad_size_i, job_pt_size_i,
               job_delay_i, data_valid_i, data_i,
        input  job_ready_o, data_ready_o, ct_valid_o, ct_o, tag_valid_o, tag_o,
               done_o, error_o, busy_o
    );

    // Scheduler side.
    modport slave (
        input  job_valid_i, job_key_i, job_nonce_i, job_ad_size_i, job_pt_size_i,
               job_delay_i, data_valid_i, data_i,
        output job_ready_o, data_ready_o, ct_valid_o, ct_o, tag_valid_o, tag_o,
               done_o, error_o, busy_o
    );

endinterface

// File: rtl/ascon_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            found
);
    logic [IW-1:0] cand;

    // Scan candidates in priority order starting at ptr and keep the first hit.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/ascon_job_sched.sv
// Round-robin scheduler sharing one ascon_top core between NREQ requesters,
// with a watchdog that aborts hung jobs by pulsing the core reset.
module ascon_job_sched
    import ascon_pack::*;
#(
    parameter int NREQ      = 2,
    parameter int BLK_AD_AW = 10,
    parameter int BLK_PT_AW = 10,
    parameter int WDOG_W    = WDOG_DEF_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ascon_job_sched_if.slave     jobs,
    output logic                 core_rst_o,
    output logic                 core_start_o,
    output logic                 core_data_valid_o,
    output logic [63:0]          core_data_o,
    output logic [127:0]         core_key_o,
    output logic [127:0]         core_nonce_o,
    output logic [BLK_AD_AW-1:0] core_ad_size_o,
    output logic [BLK_PT_AW-1:0] core_pt_size_o,
    output logic [7:0]           core_delay_o,
    input  logic                 core_ready_i,
    input  logic                 core_data_req_i,
    input  logic                 core_done_i,
    input  logic                 core_ct_valid_i,
    input  logic                 core_tag_valid_i,
    input  logic [63:0]          core_ct_i,
    input  logic [127:0]         core_tag_i
);
    localparam int IW = $clog2(NREQ);
    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    logic [1:0]        state;
    logic [IW-1:0]     g;
    logic [IW-1:0]     rr;
    logic [WDOG_W-1:0] wdog;
    logic              pend;
    logic              abort_cnt;

    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_found;

    logic [NREQ-1:0]   g_onehot;
    logic              hs;
    logic              activity;
    logic [WDOG_W-1:0] wdog_inc;
    logic [IW-1:0]     rr_after;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (jobs.job_valid_i),
        .ptr   (rr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    assign g_onehot = NREQ'(1) << g;

    // Only the owner sees ready, and only while no word is waiting to go to the core.
    assign jobs.data_ready_o = (state == ST_RUN && core_data_req_i && !pend) ? g_onehot : '0;
    assign hs       = |(jobs.data_valid_i & jobs.data_ready_o);
    assign activity = hs | core_ct_valid_i | core_tag_valid_i;
    assign wdog_inc = (wdog == WDOG_MAX) ? wdog : wdog + WDOG_W'(1);
    assign rr_after = (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
    assign jobs.busy_o = (state != ST_IDLE);

    // Scheduler FSM, descriptor latch, data forwarding, result routing and watchdog.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= ST_IDLE;
            g                 <= '0;
            rr                <= '0;
            wdog              <= '0;
            pend              <= 1'b0;
            abort_cnt         <= 1'b0;
            jobs.job_ready_o  <= '0;
            jobs.ct_valid_o   <= '0;
            jobs.ct_o         <= '0;
            jobs.tag_valid_o  <= '0;
            jobs.tag_o        <= '0;
            jobs.done_o       <= '0;
            jobs.error_o      <= '0;
            core_rst_o        <= 1'b0;
            core_start_o      <= 1'b0;
            core_data_valid_o <= 1'b0;
            core_data_o       <= '0;
            core_key_o        <= '0;
            core_nonce_o      <= '0;
            core_ad_size_o    <= '0;
            core_pt_size_o    <= '0;
            core_delay_o      <= '0;
        end else begin
            jobs.job_ready_o  <= '0;
            jobs.ct_valid_o   <= '0;
            jobs.tag_valid_o  <= '0;
            jobs.done_o       <= '0;
            jobs.error_o      <= '0;
            core_start_o      <= 1'b0;
            core_data_valid_o <= hs;

            if (hs) begin
                core_data_o <= jobs.data_i[g*64 +: 64];
                pend        <= 1'b1;
            end else if (core_data_valid_o) begin
                pend <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (core_ready_i && arb_found) begin
                        g                <= arb_idx;
                        core_key_o       <= jobs.job_key_i[arb_idx*128 +: 128];
                        core_nonce_o     <= jobs.job_nonce_i[arb_idx*128 +: 128];
                        core_ad_size_o   <= jobs.job_ad_size_i[arb_idx*BLK_AD_AW +: BLK_AD_AW];
                        core_pt_size_o   <= jobs.job_pt_size_i[arb_idx*BLK_PT_AW +: BLK_PT_AW];
                        core_delay_o     <= jobs.job_delay_i[arb_idx*8 +: 8];
                        jobs.job_ready_o <= arb_gnt;
                        state            <= ST_START;
                    end
                end
                ST_START: begin
                    core_start_o <= 1'b1;
                    wdog         <= '0;
                    state        <= ST_RUN;
                end
                ST_RUN: begin
                    if (core_ct_valid_i) begin
                        jobs.ct_valid_o <= g_onehot;
                        jobs.ct_o       <= core_ct_i;
                    end
                    if (core_tag_valid_i) begin
                        jobs.tag_valid_o <= g_onehot;
                        jobs.tag_o       <= core_tag_i;
                    end
                    if (core_done_i) begin
                        jobs.done_o <= g_onehot;
                        rr          <= rr_after;
                        state       <= ST_IDLE;
                    end else if (activity) begin
                        wdog <= '0;
                    end else begin
                        wdog <= wdog_inc;
                        if (wdog_inc == WDOG_MAX) begin
                            jobs.error_o <= g_onehot;
                            rr           <= rr_after;
                            core_rst_o   <= 1'b1;
                            abort_cnt    <= 1'b0;
                            state        <= ST_ABORT;
                        end
                    end
                end
                ST_ABORT: begin
                    pend <= 1'b0;
                    if (abort_cnt) begin
                        core_rst_o <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        abort_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_job_sched.sv
// Scoreboard bench for ascon_job_sched: directed jobs with a small core model.
module tb_ascon_job_sched;
    localparam int NREQ = 2;
    localparam int K_JRDY = 0, K_DATA = 1, K_CT = 2, K_TAG = 3, K_DONE = 4, K_ERR = 5;

    typedef struct {
        int           kind;
        int           idx;
        logic [127:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;

    logic         core_rst_o, core_start_o, core_data_valid_o;
    logic [63:0]  core_data_o;
    logic [127:0] core_key_o, core_nonce_o;
    logic [9:0]   core_ad_size_o, core_pt_size_o;
    logic [7:0]   core_delay_o;
    logic         core_ready_i = 1'b1;
    logic         core_data_req_i = 1'b0;
    logic         core_done_i = 1'b0;
    logic         core_ct_valid_i = 1'b0;
    logic         core_tag_valid_i = 1'b0;
    logic [63:0]  core_ct_i = '0;
    logic [127:0] core_tag_i = '0;

    int total = 0;
    int bad = 0;
    int dr_seen = 0;
    int done_seen = 0;
    int err_seen = 0;
    int jobno = 0;
    exp_t sbq[$];
    logic [127:0] exp_key[NREQ];
    logic [127:0] exp_nonce[NREQ];
    logic [27:0]  exp_misc[NREQ];

    ascon_job_sched_if #(.NREQ(NREQ), .BLK_AD_AW(10), .BLK_PT_AW(10)) bus();

    ascon_job_sched #(.NREQ(NREQ), .BLK_AD_AW(10), .BLK_PT_AW(10), .WDOG_W(4)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .jobs              (bus.slave),
        .core_rst_o        (core_rst_o),
        .core_start_o      (core_start_o),
        .core_data_valid_o (core_data_valid_o),
        .core_data_o       (core_data_o),
        .core_key_o        (core_key_o),
        .core_nonce_o      (core_nonce_o),
        .core_ad_size_o    (core_ad_size_o),
        .core_pt_size_o    (core_pt_size_o),
        .core_delay_o      (core_delay_o),
        .core_ready_i      (core_ready_i),
        .core_data_req_i   (core_data_req_i),
        .core_done_i       (core_done_i),
        .core_ct_valid_i   (core_ct_valid_i),
        .core_tag_valid_i  (core_tag_valid_i),
        .core_ct_i         (core_ct_i),
        .core_tag_i        (core_tag_i)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    function automatic string kname(input int k);
        case (k)
            K_JRDY:  return "job_ready";
            K_DATA:  return "core_data";
            K_CT:    return "ct";
            K_TAG:   return "tag";
            K_DONE:  return "done";
            default: return "error";
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_push(input int kind, input int idx, input logic [127:0] val);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input int kind, input int idx, input logic [127:0] val);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got %s[%0d]=%h expected nothing", kname(kind), idx, val);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.idx != idx || e.val !== val) begin
                bad++;
                $display("FAIL sb_%s: got %s[%0d]=%h expected %s[%0d]=%h",
                         kname(e.kind), kname(kind), idx, val, kname(e.kind), e.idx, e.val);
            end
        end
    endtask

    // Monitor: every DUT output strobe is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.data_ready_o != '0) dr_seen++;
        if ($countones(bus.job_ready_o) > 1) begin
            total++;
            bad++;
            $display("FAIL job_ready_onehot: got %b expected at most one bit", bus.job_ready_o);
        end
        for (int i = 0; i < NREQ; i++)
            if (bus.job_ready_o[i]) sb_check(K_JRDY, i, '0);
        if (core_data_valid_o) sb_check(K_DATA, 0, {64'h0, core_data_o});
        for (int i = 0; i < NREQ; i++)
            if (bus.ct_valid_o[i]) sb_check(K_CT, i, {64'h0, bus.ct_o});
        for (int i = 0; i < NREQ; i++)
            if (bus.tag_valid_o[i]) sb_check(K_TAG, i, bus.tag_o);
        for (int i = 0; i < NREQ; i++)
            if (bus.done_o[i]) begin
                done_seen++;
                sb_check(K_DONE, i, '0);
            end
        for (int i = 0; i < NREQ; i++)
            if (bus.error_o[i]) begin
                err_seen++;
                sb_check(K_ERR, i, '0);
            end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobes"},
            {bus.job_ready_o, bus.data_ready_o, bus.ct_valid_o, bus.tag_valid_o,
             bus.done_o, bus.error_o, bus.busy_o, core_rst_o, core_start_o, core_data_valid_o}, '0);
        chk({tag, "_ct_data"}, {core_data_o, bus.ct_o}, '0);
        chk({tag, "_tag"}, bus.tag_o, '0);
        chk({tag, "_key"}, core_key_o ^ core_nonce_o, '0);
        chk({tag, "_sizes"}, {core_ad_size_o, core_pt_size_o, core_delay_o}, '0);
    endtask

    // Present a descriptor on requester r and expect its acceptance strobe.
    task automatic submit(input int r, input int nad, input int npt);
        logic [127:0] key;
        jobno++;
        key = {96'h0123_4567_89AB_CDEF_0011_2233, 32'(r * 256 + jobno)};
        bus.job_key_i[r*128 +: 128]  = key;
        bus.job_nonce_i[r*128 +: 128] = ~key;
        bus.job_ad_size_i[r*10 +: 10] = 10'(nad);
        bus.job_pt_size_i[r*10 +: 10] = 10'(npt);
        bus.job_delay_i[r*8 +: 8]     = 8'(r + 3);
        exp_key[r]   = key;
        exp_nonce[r] = ~key;
        exp_misc[r]  = {10'(nad), 10'(npt), 8'(r + 3)};
        bus.job_valid_i[r] = 1'b1;
        sb_push(K_JRDY, r, '0);
    endtask

    // Wait for requester r to be accepted, then check descriptor and start latency.
    task automatic wait_accept(input int r, input bit hold);
        bit ok = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.job_ready_o[r]) begin
                ok = 1;
                break;
            end
        end
        chk($sformatf("accept_r%0d", r), 128'(ok), 128'd1);
        bus.job_valid_i[r] = hold;
        chk("desc_key", core_key_o, exp_key[r]);
        chk("desc_nonce", core_nonce_o, exp_nonce[r]);
        chk("desc_misc", 128'({core_ad_size_o, core_pt_size_o, core_delay_o}), 128'(exp_misc[r]));
        chk("start_before", 128'(core_start_o), 128'd0);
        tick();
        chk("start_latency", 128'(core_start_o), 128'd1);
    endtask

    // Core model: request nad+npt words, emit ct for PT words, then tag and done.
    task automatic core_serve(input int r, input int nad, input int npt, input logic [63:0] base,
                              input logic [127:0] tagv, input int next_r);
        logic [63:0] word;
        bit ok;
        for (int w = 0; w < nad + npt; w++) begin
            word = base + 64'(w);
            sb_push(K_DATA, 0, {64'h0, word});
            bus.data_i[r*64 +: 64] = word;
            bus.data_valid_i[r]    = 1'b1;
            core_data_req_i        = 1'b1;
            ok = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (core_data_valid_o) begin
                    ok = 1;
                    break;
                end
            end
            core_data_req_i     = 1'b0;
            bus.data_valid_i[r] = 1'b0;
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL data_handshake: got no core_data_valid_o expected word %h", word);
            end
            tick();
            if (w >= nad) begin
                sb_push(K_CT, r, {64'h0, ~word});
                core_ct_valid_i = 1'b1;
                core_ct_i       = ~word;
                tick();
                core_ct_valid_i = 1'b0;
            end
        end
        sb_push(K_TAG, r, tagv);
        core_tag_valid_i = 1'b1;
        core_tag_i       = tagv;
        tick();
        core_tag_valid_i = 1'b0;
        tick();
        sb_push(K_DONE, r, '0);
        if (next_r >= 0) submit(next_r, 1, 1);
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        chk("busy_after_done", 128'(bus.busy_o), 128'd0);
    endtask

    initial begin
        int dr0, dn0, er0, cyc, nrst;
        bit quiet;
        bus.job_valid_i   = '0;
        bus.job_key_i     = '0;
        bus.job_nonce_i   = '0;
        bus.job_ad_size_i = '0;
        bus.job_pt_size_i = '0;
        bus.job_delay_i   = '0;
        bus.data_valid_i  = '0;
        bus.data_i        = '0;

        // Reset with both requesters already holding a job.
        submit(0, 1, 1);
        submit(1, 1, 1);
        sbq.delete();
        sb_push(K_JRDY, 0, '0);
        repeat (3) tick();
        chk_all_zero("reset");
        rst_i = 1'b0;

        // Round-robin order 0,1,0,1 with both valid held high.
        for (int k = 0; k < 4; k++) begin
            if (k > 0) sb_push(K_JRDY, k % 2, '0);
            wait_accept(k % 2, 1'b1);
            core_serve(k % 2, 1, 1, 64'hA000_0000_0000_0000 + 64'(k * 16),
                       {96'h0, 32'hCAFE_0000 + 32'(k)}, -1);
        end
        bus.job_valid_i = '0;
        tick();

        // Requester 0: ad=2, pt=3.
        submit(0, 2, 3);
        wait_accept(0, 1'b0);
        core_serve(0, 2, 3, 64'h1111_2222_3333_0000, 128'hFEED_BEEF_0000_0000_0000_0000_1234_5678, -1);
        tick();

        // Requester 1 withholds data: watchdog abort after 15 idle cycles.
        submit(1, 1, 1);
        wait_accept(1, 1'b0);
        sb_push(K_ERR, 1, '0);
        core_data_req_i = 1'b1;
        quiet = 1;
        cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (bus.error_o[1]) begin
                cyc = c;
                break;
            end
            if (bus.data_ready_o != 2'b10 || core_data_valid_o) quiet = 0;
        end
        chk("wdog_cycles", 128'(cyc), 128'd15);
        chk("wdog_hold_ready", 128'(quiet), 128'd1);
        nrst = 0;
        for (int c = 0; c < 8; c++) begin
            if (!core_rst_o) break;
            nrst++;
            tick();
        end
        core_data_req_i = 1'b0;
        chk("abort_rst_len", 128'(nrst), 128'd2);
        chk("abort_idle", 128'(bus.busy_o), 128'd0);

        // Empty job: no data requests but tag and done still delivered.
        dr0 = dr_seen;
        submit(0, 0, 0);
        wait_accept(0, 1'b0);
        core_serve(0, 0, 0, 64'h0, 128'h0BAD_F00D_0000_0000_0000_0000_0000_0042, -1);
        chk("empty_no_ready", 128'(dr_seen - dr0), 128'd0);
        tick();

        // Reset in the middle of a requester-1 job.
        submit(1, 1, 1);
        wait_accept(1, 1'b0);
        sb_push(K_DATA, 0, {64'h0, 64'h5555_6666_7777_8888});
        bus.data_i[64 +: 64] = 64'h5555_6666_7777_8888;
        bus.data_valid_i[1]  = 1'b1;
        core_data_req_i      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (core_data_valid_o) break;
        end
        dn0 = done_seen;
        er0 = err_seen;
        rst_i = 1'b1;
        bus.data_valid_i = '0;
        core_data_req_i  = 1'b0;
        tick();
        rst_i = 1'b0;
        chk_all_zero("midrst");
        chk("midrst_state", 128'(dut.state), 128'd0);
        chk("midrst_rr", 128'(dut.rr), 128'd0);
        repeat (10) tick();
        chk("midrst_no_done_err", 128'((done_seen - dn0) + (err_seen - er0)), 128'd0);

        // New job arrives in the same cycle as done.
        submit(0, 0, 0);
        wait_accept(0, 1'b0);
        core_serve(0, 0, 0, 64'h0, 128'h7777, 1);
        chk("no_grant_at_done", 128'(bus.job_ready_o), 128'd0);
        wait_accept(1, 1'b0);
        core_serve(1, 1, 1, 64'h9999_0000_0000_0000, 128'h8888, -1);

        repeat (5) tick();
        chk("sb_empty", 128'(sbq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_job_sched.md
Name: ascon_job_sched

Overview:
- Shares one `ascon_top` encryption core between NREQ requesters (default 2). Each requester supplies a job descriptor (key, nonce, AD/PT block counts, delay) and a 64-bit data stream.
- The scheduler picks requesters round-robin and sequences the core: start, data feeding on the core's request, and routing of ciphertext, tag and done back to the owner.
- A watchdog aborts a hung job by resetting the core.
- Sits between the bus-side requesters and `ascon_top`.

Parameters:
- NREQ, 2, number of requesters (2..4)
- BLK_AD_AW, 10, AD block-count width
- BLK_PT_AW, 10, PT block-count width
- WDOG_W, 12, watchdog counter width; timeout = 2**WDOG_W-1 idle cycles

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- job_valid_i  in  NREQ  descriptor valid per requester
- job_ready_o  out  NREQ  one-cycle descriptor accept
- job_key_i  in  NREQ*128  keys, packed, requester 0 in LSBs
- job_nonce_i  in  NREQ*128  nonces, packed
- job_ad_size_i  in  NREQ*BLK_AD_AW  AD block counts, packed
- job_pt_size_i  in  NREQ*BLK_PT_AW  PT block counts, packed
- job_delay_i  in  NREQ*8  inter-round delays, packed
- data_valid_i  in  NREQ  data word valid
- data_i  in  NREQ*64  data words, packed
- data_ready_o  out  NREQ  data word accepted
- ct_valid_o  out  NREQ  ciphertext block strobe to owner
- ct_o  out  64  ciphertext, broadcast
- tag_valid_o  out  NREQ  tag strobe to owner
- tag_o  out  128  tag, broadcast
- done_o  out  NREQ  job complete pulse
- error_o  out  NREQ  watchdog abort pulse
- busy_o  out  1  job in flight
- core_rst_o  out  1  core reset, active-high; inverted at top to drive rst_n_i
- core_start_o, core_data_valid_o  out  1  core controls
- core_data_o  out  64  core data
- core_key_o, core_nonce_o  out  128  latched descriptor
- core_ad_size_o  out  BLK_AD_AW  latched descriptor
- core_pt_size_o  out  BLK_PT_AW  latched descriptor
- core_delay_o  out  8  latched descriptor
- core_ready_i, core_data_req_i, core_done_i, core_ct_valid_i, core_tag_valid_i  in  1  core status
- core_ct_i  in  64  core ciphertext
- core_tag_i  in  128  core tag

Behaviour:
- Reset (rst_i sampled high at clk edge):
  - All outputs 0; descriptor registers 0.
  - State IDLE; grant index g=0; round-robin pointer rr=0; watchdog=0.
  - Applies mid-job too: the job is discarded, no done_o/error_o is issued, and core_rst_o stays 0 (the core is reset by the system reset).
- States: IDLE, START, RUN, ABORT.
- IDLE:
  - If core_ready_i=1 and any job_valid_i bit is set, grant the first set bit searching from rr upward, wrapping modulo NREQ.
  - Latch that requester's descriptor into the core_* registers and pulse job_ready_o[g] for one cycle. Go to START.
  - busy_o=0 only in IDLE.
- START: core_start_o=1 for exactly one cycle; clear the watchdog; go to RUN. The descriptor is stable on core_* from the cycle before start.
- RUN, data path:
  - data_ready_o[g] = core_data_req_i & ~pend; all other data_ready_o bits are 0.
  - On data_valid_i[g] & data_ready_o[g]: register core_data_o <= word and set pend.
  - The next cycle asserts core_data_valid_o=1 for exactly one cycle, then clears pend.
  - Exactly one word per request edge; at most one word per 2 cycles.
- RUN, result routing (registered, 1-cycle latency):
  - core_ct_valid_i -> ct_valid_o[g] with ct_o=core_ct_i.
  - core_tag_valid_i -> tag_valid_o[g] with tag_o=core_tag_i.
  - There is no backpressure on ct/tag.
- RUN, completion: on core_done_i, pulse done_o[g] next cycle, set rr=(g+1) mod NREQ, go to IDLE.
  - If a new job is valid in the same cycle as done, it is granted no earlier than the cycle after IDLE is entered.
- Watchdog (RUN only):
  - Cleared on any data handshake, core_ct_valid_i or core_tag_valid_i; otherwise increments.
  - On reaching all-ones: pulse error_o[g], go to ABORT, set rr=(g+1) mod NREQ.
  - The counter saturates and never wraps.
- ABORT: core_rst_o=1 for 2 cycles, clear pend, then go to IDLE. No done_o is issued.
- Sizes: ad_size=0 and pt_size=0 are legal; the job completes with no data requests.
- Non-granted requesters: data_valid_i is ignored; the ct/tag/done/error bits stay 0.

Decomposition:
- Package `ascon_pack` holds the sched_state_e enum (IDLE, START, RUN, ABORT) and constant WDOG_DEF_W=12.
- Sub-module `rr_arbiter` (NREQ-wide request, rr pointer in, one-hot grant plus index out) is combinational and reused for future shared cores.
- The watchdog reuses the existing `timer` if its load/enable semantics fit; otherwise it is inline.

Test Plan:
- Req0 job ad=2, pt=3, core model requests 5 words -> core_start_o one cycle after job_ready_o[0]; 5 data handshakes; ct_valid_o[0] pulses 3 times; tag_valid_o[0] once; done_o[0] once; busy_o back to 0.
- Both job_valid_i high from reset -> grants in order 0, 1, 0, 1 over 4 jobs; job_ready_o never set for 2 bits at once.
- Req1 stream withholds data_valid_i for 20 cycles while core_data_req_i=1 -> no core_data_valid_o, data_ready_o[1] held at 1; with WDOG_W=4, error_o[1] at 15 idle cycles, core_rst_o high 2 cycles, then IDLE.
- ad=0, pt=0 job -> zero data_ready_o pulses, tag_valid_o and done_o still delivered to the owner.
- rst_i asserted mid-RUN -> next cycle all outputs 0, state IDLE, rr=0, no done_o/error_o.
- New job valid in the same cycle as core_done_i -> done_o pulses, and job_ready_o for the new job arrives no earlier than one cycle after entering IDLE.
